redundant_to_binary: RTL

- Consumes one redundant-form result from the multiplier/Montgomery datapath and emits it as canonical WORD_LEN-bit words, LSW first.
- Input is NUM_ELEMENTS coefficients of DSP_BIT_LEN bits, each weighted 2^(WORD_LEN*i). Carry is resolved serially, one word per cycle.
- Sits between the squaring pipeline output and the host/result streaming path. It is the reader and normaliser for the redundant coefficient format that the multiplier writes.

---
 rtl/redundant_to_binary.sv | 127 ++++++++++++
 1 files changed

// File: rtl/redundant_to_binary.sv
// Serial normaliser: takes NUM_ELEMENTS redundant coefficients (weight 2^(WORD_LEN*i))
// and streams canonical WORD_LEN-bit words LSW first, resolving one carry per beat.
module redundant_to_binary #(
    parameter int NUM_ELEMENTS = 33,
    parameter int DSP_BIT_LEN  = 17,
    parameter int WORD_LEN     = 16,
    localparam int CARRY_LEN   = DSP_BIT_LEN - WORD_LEN + 1,
    localparam int IDX_LEN     = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_val,
    output logic                                    o_rdy,
    input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] i_dat,
    output logic                                    o_val,
    input  logic                                    i_rdy,
    output logic [WORD_LEN-1:0]                     o_word,
    output logic [IDX_LEN-1:0]                      o_idx,
    output logic                                    o_last,
    output logic [CARRY_LEN-1:0]                    o_carry,
    output logic                                    o_state
);

    // Handshake: an input operand moves on i_val && o_rdy; an output word moves on
    // o_val && i_rdy. While a side waits, the offering side holds its payload stable.
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                                   state_q, state_d;
    logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] store_q, store_d;
    logic [CARRY_LEN-1:0]                     carry_q, carry_d;
    logic                                     o_rdy_q, o_rdy_d;
    logic                                     o_val_q, o_val_d;
    logic [WORD_LEN-1:0]                      o_word_q, o_word_d;
    logic [IDX_LEN-1:0]                       o_idx_q, o_idx_d;
    logic                                     o_last_q, o_last_d;
    logic [CARRY_LEN-1:0]                     o_carry_q, o_carry_d;

    logic [IDX_LEN-1:0]                       nxt_idx;
    logic [DSP_BIT_LEN:0]                     sum;

    assign nxt_idx = o_idx_q + 1'b1;
    assign sum     = {1'b0, store_q[nxt_idx]} + (DSP_BIT_LEN+1)'(carry_q);

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        carry_d   = carry_q;
        o_rdy_d   = o_rdy_q;
        o_val_d   = o_val_q;
        o_word_d  = o_word_q;
        o_idx_d   = o_idx_q;
        o_last_d  = o_last_q;
        o_carry_d = o_carry_q;
        case (state_q)
            S_IDLE: begin
                o_rdy_d = 1'b1;
                o_val_d = 1'b0;
                if (i_val && o_rdy_q) begin
                    store_d   = i_dat;
                    o_word_d  = i_dat[0][WORD_LEN-1:0];
                    carry_d   = CARRY_LEN'(i_dat[0][DSP_BIT_LEN-1:WORD_LEN]);
                    o_idx_d   = '0;
                    o_last_d  = (NUM_ELEMENTS == 1);
                    o_carry_d = (NUM_ELEMENTS == 1) ? carry_d : '0;
                    o_val_d   = 1'b1;
                    o_rdy_d   = 1'b0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (o_val_q && i_rdy) begin
                    if (o_last_q) begin
                        o_val_d   = 1'b0;
                        o_last_d  = 1'b0;
                        o_carry_d = '0;
                        o_rdy_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        o_word_d  = sum[WORD_LEN-1:0];
                        carry_d   = sum[DSP_BIT_LEN:WORD_LEN];
                        o_idx_d   = nxt_idx;
                        o_last_d  = (nxt_idx == IDX_LEN'(NUM_ELEMENTS-1));
                        // The final carry is only exposed alongside the top word.
                        o_carry_d = o_last_d ? carry_d : '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            store_q   <= '0;
            carry_q   <= '0;
            o_rdy_q   <= 1'b0;
            o_val_q   <= 1'b0;
            o_word_q  <= '0;
            o_idx_q   <= '0;
            o_last_q  <= 1'b0;
            o_carry_q <= '0;
        end else begin
            state_q   <= state_d;
            store_q   <= store_d;
            carry_q   <= carry_d;
            o_rdy_q   <= o_rdy_d;
            o_val_q   <= o_val_d;
            o_word_q  <= o_word_d;
            o_idx_q   <= o_idx_d;
            o_last_q  <= o_last_d;
            o_carry_q <= o_carry_d;
        end
    end

    assign o_rdy   = o_rdy_q;
    assign o_val   = o_val_q;
    assign o_word  = o_word_q;
    assign o_idx   = o_idx_q;
    assign o_last  = o_last_q;
    assign o_carry = o_carry_q;
    assign o_state = state_q;

endmodule
